// File: rtl/slv_fsm_pkg.sv
// Shared types and constants for the multi-slave request/response FSM.
// State encoding, error-code values and a one-hot test used by the top level.
package slv_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic ERR_OK   = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  // Select vectors are zero-extended to 32 bits; N_SLV never exceeds 32.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/slv_fsm_multi_if.sv
// Signal bundle for the master and slave sides of slv_fsm_multi.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid must not depend on ready.
interface slv_fsm_multi_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int N_SLV      = 4
);
  logic                        req_vld;
  logic                        req_rdy;
  logic                        rd_en;
  logic                        wr_en;
  logic [ADDR_WIDTH-1:0]       addr;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic [N_SLV-1:0]            sel;
  logic                        sync_reset;
  logic                        ack_vld;
  logic                        ack_rdy;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        err;

  logic [N_SLV-1:0]            slv_req_vld;
  logic [N_SLV-1:0]            slv_req_rdy;
  logic [ADDR_WIDTH-1:0]       slv_addr;
  logic [DATA_WIDTH-1:0]       slv_wr_data;
  logic                        slv_wr_en;
  logic                        slv_rd_en;
  logic                        slv_sync_reset;
  logic [N_SLV-1:0]            slv_ack_vld;
  logic [N_SLV-1:0]            slv_ack_rdy;
  logic [N_SLV*DATA_WIDTH-1:0] slv_rd_data;
  logic                        cdc_pulse;

  modport master (
    output req_vld, rd_en, wr_en, addr, wr_data, sel, sync_reset, ack_rdy,
    input  req_rdy, ack_vld, rd_data, err
  );

  modport slave (
    input  slv_req_vld, slv_addr, slv_wr_data, slv_wr_en, slv_rd_en,
           slv_sync_reset, slv_ack_rdy,
    output slv_req_rdy, slv_ack_vld, slv_rd_data
  );

  modport monitor (
    input req_vld, req_rdy, rd_en, wr_en, addr, wr_data, sel, sync_reset,
          ack_vld, ack_rdy, rd_data, err, slv_req_vld, slv_req_rdy, slv_addr,
          slv_wr_data, slv_wr_en, slv_rd_en, slv_sync_reset, slv_ack_vld,
          slv_ack_rdy, slv_rd_data, cdc_pulse
  );
endinterface

// File: rtl/slv_fsm_tmr.sv
// Saturating wait-cycle counter; expire flags the last allowed cycle of a transaction.
// TIMEOUT of 0 disables expiry entirely.
module slv_fsm_tmr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  // Holding at LAST keeps expire asserted if a late slave ready moves the FSM to WAIT_ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT > 0) && (count == LAST);

endmodule

// File: rtl/slv_fsm_multi.sv
// Routes one master request to a one-hot selected slave channel and returns a single response.
// Bad selects and slave timeouts answer with err=1 and zero read data.
module slv_fsm_multi
  import slv_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int N_SLV      = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mst__fsm__req_vld,
  output logic                        fsm__mst__req_rdy,
  input  logic                        mst__fsm__rd_en,
  input  logic                        mst__fsm__wr_en,
  input  logic [ADDR_WIDTH-1:0]       mst__fsm__addr,
  input  logic [DATA_WIDTH-1:0]       mst__fsm__wr_data,
  input  logic [N_SLV-1:0]            mst__fsm__sel,
  input  logic                        mst__fsm__sync_reset,
  output logic                        fsm__mst__ack_vld,
  input  logic                        mst__fsm__ack_rdy,
  output logic [DATA_WIDTH-1:0]       fsm__mst__rd_data,
  output logic                        fsm__mst__err,
  output logic [N_SLV-1:0]            fsm__slv__req_vld,
  input  logic [N_SLV-1:0]            slv__fsm__req_rdy,
  output logic [ADDR_WIDTH-1:0]       fsm__slv__addr,
  output logic [DATA_WIDTH-1:0]       fsm__slv__wr_data,
  output logic                        fsm__slv__wr_en,
  output logic                        fsm__slv__rd_en,
  output logic                        fsm__slv__sync_reset,
  input  logic [N_SLV-1:0]            slv__fsm__ack_vld,
  output logic [N_SLV-1:0]            fsm__slv__ack_rdy,
  input  logic [N_SLV*DATA_WIDTH-1:0] slv__fsm__rd_data,
  output logic                        cdc_pulse_out
);
  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_q, rd_q;
  logic [N_SLV-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  cdc_q;

  logic                  accept, hit_rdy, hit_ack, busy;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  tmr_clear, tmr_en, tmr_expire;
  logic                  load_resp, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  assign accept  = mst__fsm__req_vld & fsm__mst__req_rdy;
  assign hit_rdy = |(slv__fsm__req_rdy & sel_q);
  assign hit_ack = |(slv__fsm__ack_vld & sel_q);
  assign busy    = (state == ST_WAIT_RDY) || (state == ST_WAIT_ACK);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | slv__fsm__rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  slv_fsm_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cdc_q <= 1'b0;
    end else begin
      state <= state_n;
      cdc_q <= (state_n != state);
    end
  end

  // A completing handshake is checked before expiry so it wins in the last cycle.
  always_comb begin
    state_n   = state;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    load_resp = 1'b0;
    resp_err  = ERR_OK;
    resp_data = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_onehot(32'(mst__fsm__sel))) begin
            state_n   = ST_WAIT_RDY;
            tmr_clear = 1'b1;
          end else begin
            state_n   = ST_RESP;
            load_resp = 1'b1;
            resp_err  = ERR_FAIL;
          end
        end
      end
      ST_WAIT_RDY: begin
        tmr_en = 1'b1;
        if (hit_rdy && hit_ack) begin
          state_n   = ST_RESP;
          load_resp = 1'b1;
          resp_data = rd_mux;
        end else if (hit_rdy) begin
          state_n = ST_WAIT_ACK;
        end else if (tmr_expire) begin
          state_n   = ST_RESP;
          load_resp = 1'b1;
          resp_err  = ERR_FAIL;
        end
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        if (hit_ack) begin
          state_n   = ST_RESP;
          load_resp = 1'b1;
          resp_data = rd_mux;
        end else if (tmr_expire) begin
          state_n   = ST_RESP;
          load_resp = 1'b1;
          resp_err  = ERR_FAIL;
        end
      end
      ST_RESP: begin
        if (mst__fsm__ack_rdy) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (mst__fsm__sync_reset) begin
      state_n   = ST_IDLE;
      load_resp = 1'b0;
      tmr_clear = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (mst__fsm__sync_reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= mst__fsm__addr;
        wdata_q <= mst__fsm__wr_data;
        wr_q    <= mst__fsm__wr_en;
        rd_q    <= mst__fsm__rd_en;
        sel_q   <= mst__fsm__sel;
      end
      if (load_resp) begin
        rdata_q <= resp_data;
        err_q   <= resp_err;
      end
    end
  end

  // rst gates ready directly because the async reset holds state at IDLE.
  assign fsm__mst__req_rdy    = (state == ST_IDLE) & ~mst__fsm__sync_reset & ~rst;
  assign fsm__mst__ack_vld    = (state == ST_RESP);
  assign fsm__mst__rd_data    = fsm__mst__ack_vld ? rdata_q : '0;
  assign fsm__mst__err        = fsm__mst__ack_vld & err_q;

  assign fsm__slv__req_vld    = (state == ST_WAIT_RDY) ? sel_q : '0;
  assign fsm__slv__ack_rdy    = (state == ST_WAIT_ACK) ? sel_q : '0;
  assign fsm__slv__addr       = busy ? addr_q : '0;
  assign fsm__slv__wr_data    = busy ? wdata_q : '0;
  assign fsm__slv__wr_en      = busy & wr_q;
  assign fsm__slv__rd_en      = busy & rd_q;
  assign fsm__slv__sync_reset = mst__fsm__sync_reset;
  assign cdc_pulse_out        = cdc_q;

endmodule

// File: tb/tb_slv_fsm_multi.sv
// Bench for slv_fsm_multi: directed transactions, expected responses queued by the driver
// and consumed by a monitor that compares every presented response.
module tb_slv_fsm_multi;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slv_fsm_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS)) bif ();
  slv_fsm_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS)) nif ();

  slv_fsm_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mst__fsm__req_vld(bif.req_vld), .fsm__mst__req_rdy(bif.req_rdy),
    .mst__fsm__rd_en(bif.rd_en), .mst__fsm__wr_en(bif.wr_en),
    .mst__fsm__addr(bif.addr), .mst__fsm__wr_data(bif.wr_data),
    .mst__fsm__sel(bif.sel), .mst__fsm__sync_reset(bif.sync_reset),
    .fsm__mst__ack_vld(bif.ack_vld), .mst__fsm__ack_rdy(bif.ack_rdy),
    .fsm__mst__rd_data(bif.rd_data), .fsm__mst__err(bif.err),
    .fsm__slv__req_vld(bif.slv_req_vld), .slv__fsm__req_rdy(bif.slv_req_rdy),
    .fsm__slv__addr(bif.slv_addr), .fsm__slv__wr_data(bif.slv_wr_data),
    .fsm__slv__wr_en(bif.slv_wr_en), .fsm__slv__rd_en(bif.slv_rd_en),
    .fsm__slv__sync_reset(bif.slv_sync_reset), .slv__fsm__ack_vld(bif.slv_ack_vld),
    .fsm__slv__ack_rdy(bif.slv_ack_rdy), .slv__fsm__rd_data(bif.slv_rd_data),
    .cdc_pulse_out(bif.cdc_pulse)
  );

  slv_fsm_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLV(NS), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst),
    .mst__fsm__req_vld(nif.req_vld), .fsm__mst__req_rdy(nif.req_rdy),
    .mst__fsm__rd_en(nif.rd_en), .mst__fsm__wr_en(nif.wr_en),
    .mst__fsm__addr(nif.addr), .mst__fsm__wr_data(nif.wr_data),
    .mst__fsm__sel(nif.sel), .mst__fsm__sync_reset(nif.sync_reset),
    .fsm__mst__ack_vld(nif.ack_vld), .mst__fsm__ack_rdy(nif.ack_rdy),
    .fsm__mst__rd_data(nif.rd_data), .fsm__mst__err(nif.err),
    .fsm__slv__req_vld(nif.slv_req_vld), .slv__fsm__req_rdy(nif.slv_req_rdy),
    .fsm__slv__addr(nif.slv_addr), .fsm__slv__wr_data(nif.slv_wr_data),
    .fsm__slv__wr_en(nif.slv_wr_en), .fsm__slv__rd_en(nif.slv_rd_en),
    .fsm__slv__sync_reset(nif.slv_sync_reset), .slv__fsm__ack_vld(nif.slv_ack_vld),
    .fsm__slv__ack_rdy(nif.slv_ack_rdy), .slv__fsm__rd_data(nif.slv_rd_data),
    .cdc_pulse_out(nif.cdc_pulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int vld_total = 0;
  int done_cnt = 0;
  bit in_resp = 1'b0;
  logic [48:0] exp_q[$];  // {err, rd_data, latency}
  logic [48:0] e;

  logic [NS-1:0] cur_sel;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          cur_wr, cur_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on response handshake, slave-side sanity every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.req_vld && bif.req_rdy) acc_cyc = cyc;
      if (bif.slv_req_vld != '0) begin
        vld_total++;
        check("slv_req_vld_sel", 64'(bif.slv_req_vld), 64'(cur_sel));
        check("slv_addr", bif.slv_addr, cur_addr);
        check("slv_wr_data", 64'(bif.slv_wr_data), 64'(cur_data));
        check("slv_wr_rd_en", {62'd0, bif.slv_wr_en, bif.slv_rd_en}, {62'd0, cur_wr, cur_rd});
      end
      if (bif.ack_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(bif.ack_vld), 64'd0);
        end else begin
          e = exp_q[0];
          if (!in_resp) begin
            check("latency", 64'(cyc - acc_cyc), 64'(e[15:0]));
            in_resp = 1'b1;
          end
          check("resp_err", 64'(bif.err), 64'(e[48]));
          check("resp_data", 64'(bif.rd_data), 64'(e[47:16]));
          check("resp_slv_quiet", 64'({bif.slv_req_vld, bif.slv_ack_rdy, bif.slv_wr_en, bif.slv_rd_en}), 64'd0);
          if (bif.ack_rdy) begin
            void'(exp_q.pop_front());
            in_resp = 1'b0;
            done_cnt++;
          end
        end
      end else begin
        check("no_ack_zero", 64'({bif.err, bif.rd_data}), 64'd0);
      end
    end
  end

  task automatic accept_req(input string tag, input logic [NS-1:0] sel, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic acc;
    int n;
    cur_sel = sel; cur_addr = addr; cur_data = wdata; cur_wr = wr; cur_rd = !wr;
    bif.req_vld = 1'b1; bif.sel = sel; bif.wr_en = wr; bif.rd_en = !wr;
    bif.addr = addr; bif.wr_data = wdata;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = bif.req_rdy;
      @(posedge clk); #1; n++;
    end
    check({tag, "_accept"}, 64'(acc), 64'd1);
    bif.req_vld = 1'b0; bif.wr_en = 1'b0; bif.rd_en = 1'b0; bif.sel = '0;
  endtask

  // rdy_at/ack_at: cycle index after accept (1 = first WAIT_RDY cycle), 0 = never.
  task automatic run_txn(input string tag, input logic [NS-1:0] sel, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdval, input int rdy_at, input int ack_at,
                         input bit noise, input bit exp_err, input logic [DW-1:0] exp_data,
                         input int exp_lat, input int exp_vld, input int hold);
    int vld0, d0;
    logic [NS-1:0] nz;
    nz = noise ? ~sel : '0;
    for (int i = 0; i < NS; i++)
      bif.slv_rd_data[i*DW +: DW] = sel[i] ? rdval : (32'hBAD0_0000 | 32'(i));
    bif.slv_req_rdy = nz;
    bif.slv_ack_vld = nz;
    bif.ack_rdy = (hold == 0);
    exp_q.push_back({exp_err, exp_data, 16'(exp_lat)});
    vld0 = vld_total; d0 = done_cnt;
    accept_req(tag, sel, wr, addr, wdata);
    for (int k = 1; k <= 40; k++) begin
      bif.slv_req_rdy = nz | ((k == rdy_at) ? sel : '0);
      bif.slv_ack_vld = nz | ((k == ack_at) ? sel : '0);
      if (hold > 0 && k == exp_lat + hold) bif.ack_rdy = 1'b1;
      @(negedge clk);
      if (k == 1) check({tag, "_cdc_entry"}, 64'(bif.cdc_pulse), 64'd1);
      @(posedge clk); #1;
      if (done_cnt != d0) break;
    end
    check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_vld_cycles"}, 64'(vld_total - vld0), 64'(exp_vld));
    bif.slv_req_rdy = '0; bif.slv_ack_vld = '0; bif.ack_rdy = 1'b1;
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n, cnt;
    rst = 1'b1;
    bif.req_vld = 0; bif.rd_en = 0; bif.wr_en = 0; bif.addr = '0; bif.wr_data = '0;
    bif.sel = '0; bif.sync_reset = 0; bif.ack_rdy = 1; bif.slv_req_rdy = '0;
    bif.slv_ack_vld = '0; bif.slv_rd_data = '0;
    nif.req_vld = 0; nif.rd_en = 0; nif.wr_en = 0; nif.addr = '0; nif.wr_data = '0;
    nif.sel = '0; nif.sync_reset = 0; nif.ack_rdy = 1; nif.slv_req_rdy = '0;
    nif.slv_ack_vld = '0; nif.slv_rd_data = '0;
    cur_sel = '0; cur_addr = '0; cur_data = '0; cur_wr = 0; cur_rd = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", 64'(bif.req_rdy), 64'd0);
    check("rst_ack_vld", 64'(bif.ack_vld), 64'd0);
    check("rst_cdc", 64'(bif.cdc_pulse), 64'd0);
    check("rst_slv_req_vld", 64'(bif.slv_req_vld), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("idle_req_rdy", 64'(bif.req_rdy), 64'd1);
    check("idle_nt_req_rdy", 64'(nif.req_rdy), 64'd1);
    check("idle_cdc", 64'(bif.cdc_pulse), 64'd0);
    check("idle_slv_ack_rdy", 64'(bif.slv_ack_rdy), 64'd0);
    @(posedge clk); #1;

    //       tag        sel      wr  addr    wdata          rdval          rdy ack nz err exp_data       lat vld hold
    run_txn("wr_ch2",  4'b0100, 1, 64'h10, 32'hA5A5A5A5, 32'h11112222, 1,  4,  0, 0, 32'h11112222, 5,  1,  0);
    run_txn("rd_ch0",  4'b0001, 0, 64'h20, 32'h0,        32'h12345678, 1,  1,  0, 0, 32'h12345678, 2,  1,  0);
    run_txn("sel_0",   4'b0000, 0, 64'h30, 32'h0,        32'hFFFFFFFF, 1,  1,  1, 1, 32'h0,        1,  0,  0);
    run_txn("sel_3",   4'b0011, 1, 64'h34, 32'h77,       32'hFFFFFFFF, 1,  1,  1, 1, 32'h0,        1,  0,  0);
    run_txn("noise3",  4'b1000, 0, 64'h38, 32'h0,        32'hCAFEBABE, 3,  6,  1, 0, 32'hCAFEBABE, 7,  3,  0);
    run_txn("to_rdy",  4'b0010, 0, 64'h40, 32'h0,        32'h87654321, 0,  0,  0, 1, 32'h0,        17, 16, 0);
    run_txn("to_ack",  4'b0010, 1, 64'h44, 32'h9,        32'h87654321, 1,  0,  0, 1, 32'h0,        17, 1,  0);
    run_txn("ack_last",4'b0001, 0, 64'h48, 32'h0,        32'h0BADF00D, 1,  16, 0, 0, 32'h0BADF00D, 17, 1,  0);
    run_txn("both_last",4'b1000,0, 64'h4C, 32'h0,        32'h600DD00D, 16, 16, 0, 0, 32'h600DD00D, 17, 16, 0);
    run_txn("hold5",   4'b0100, 0, 64'h50, 32'h0,        32'h5A5A0FF0, 2,  2,  0, 0, 32'h5A5A0FF0, 3,  2,  5);

    // Abort from WAIT_ACK: no response may follow.
    accept_req("sync", 4'b0010, 0, 64'h60, 32'h0);
    bif.slv_req_rdy = 4'b0010; @(posedge clk); #1;
    bif.slv_req_rdy = '0;      @(posedge clk); #1;
    bif.sync_reset = 1'b1;
    @(negedge clk);
    check("sync_pass_through", 64'(bif.slv_sync_reset), 64'd1);
    check("sync_wait_ack_rdy", 64'(bif.slv_ack_rdy), 64'(4'b0010));
    @(posedge clk); #1; bif.sync_reset = 1'b0;
    @(negedge clk);
    check("sync_idle_req_rdy", 64'(bif.req_rdy), 64'd1);
    check("sync_idle_ack_vld", 64'(bif.ack_vld), 64'd0);
    check("sync_idle_ack_rdy", 64'(bif.slv_ack_rdy), 64'd0);
    @(posedge clk); #1; bif.sync_reset = 1'b1;
    @(negedge clk);
    check("sync_blocks_req_rdy", 64'(bif.req_rdy), 64'd0);
    @(posedge clk); #1; bif.sync_reset = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (bif.ack_vld) cnt++; end
    check("sync_no_resp", 64'(cnt), 64'd0);
    @(posedge clk); #1;

    // Reset in mid-transaction abandons it.
    accept_req("rstmid", 4'b0001, 1, 64'h70, 32'h33);
    bif.slv_req_rdy = 4'b0001; @(posedge clk); #1;
    bif.slv_req_rdy = '0;      @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_req_rdy", 64'(bif.req_rdy), 64'd0);
    check("rstmid_outputs", 64'({bif.ack_vld, bif.slv_ack_rdy, bif.slv_req_vld, bif.cdc_pulse}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (bif.ack_vld) cnt++; end
    check("rstmid_no_resp", 64'(cnt), 64'd0);
    check("rstmid_idle", 64'(bif.req_rdy), 64'd1);
    @(posedge clk); #1;

    // TIMEOUT=0 instance never times out.
    nif.req_vld = 1'b1; nif.sel = 4'b0001; nif.rd_en = 1'b1; nif.addr = 64'h80;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk); acc = nif.req_rdy;
      @(posedge clk); #1; n++;
    end
    check("nt_accept", 64'(acc), 64'd1);
    nif.req_vld = 1'b0; nif.rd_en = 1'b0; nif.sel = '0;
    cnt = 0;
    repeat (1000) begin @(negedge clk); if (nif.ack_vld) cnt++; end
    check("nt_no_resp", 64'(cnt), 64'd0);
    check("nt_still_waiting", 64'(nif.slv_req_vld), 64'(4'b0001));
    @(posedge clk); #1; nif.sync_reset = 1'b1;
    @(posedge clk); #1; nif.sync_reset = 1'b0;
    @(negedge clk);
    check("nt_sync_idle", 64'(nif.req_rdy), 64'd1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
